// File: rtl/hmmm_bus_pkg.sv
// rtl/hmmm_bus_pkg.sv - shared types and constants for the Hmmm bus-transfer sequencer
// Contents: state_e (transfer phases), idx_w() (register index width helper), R0 (hard-wired zero register index)
package hmmm_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_e;

    localparam int R0 = 0;

    function automatic int idx_w(input int num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/hmmm_onehot_dec.sv
// rtl/hmmm_onehot_dec.sv - index to one-hot decoder with enable
// Ports: idx (register index), en (decode enable), onehot (NUM_REGS-bit one-hot, all zero when en=0)
module hmmm_onehot_dec #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic [IDX_W-1:0]    idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/hmmm_bus_ctrl.sv
// rtl/hmmm_bus_ctrl.sv - tristate bus-transfer sequencer for the Hmmm register file
// Ports: clk, rst (sync active-high); req_valid/req_ready/req_src/req_dst/req_imm_en/req_imm request handshake;
//        reg_out_en/reg_in_en per-register output enables and load strobes; data shared tristate bus;
//        busy (DRIVE or LATCH), done (one-cycle completion pulse)
module hmmm_bus_ctrl
    import hmmm_bus_pkg::*;
#(
    parameter int N        = 16,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = idx_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDX_W-1:0]    req_src,
    input  logic [IDX_W-1:0]    req_dst,
    input  logic                req_imm_en,
    input  logic [N-1:0]        req_imm,
    output logic [NUM_REGS-1:0] reg_out_en,
    output logic [NUM_REGS-1:0] reg_in_en,
    inout  wire  [N-1:0]        data,
    output logic                busy,
    output logic                done
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    src_q, src_d;
    logic [IDX_W-1:0]    dst_q, dst_d;
    logic                imm_en_q, imm_en_d;
    logic [N-1:0]        imm_q, imm_d;
    logic                done_q, done_d;
    logic [NUM_REGS-1:0] out_en_q, out_en_d;
    logic [NUM_REGS-1:0] in_en_q, in_en_d;
    logic                drv_q, drv_d;
    logic [N-1:0]        drv_data_q, drv_data_d;

    logic active_d;
    logic src_on_bus_d;
    logic load_d;

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        imm_en_d = imm_en_q;
        imm_d    = imm_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    src_d    = req_src;
                    dst_d    = req_dst;
                    imm_en_d = req_imm_en;
                    imm_d    = req_imm;
                    state_d  = DRIVE;
                end
            end
            DRIVE: state_d = LATCH;
            LATCH: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Enables are decoded from the next-state view so they can be registered
    // and appear glitch-free in the same cycle as the phase they belong to.
    always_comb begin
        active_d     = (state_d != IDLE);
        src_on_bus_d = !imm_en_d && (src_d != IDX_W'(R0));
        load_d       = (state_d == LATCH) && (dst_d != IDX_W'(R0));
        // The controller drives exactly when no register does: immediates and r0 reads.
        drv_d        = active_d && !src_on_bus_d;
        drv_data_d   = imm_en_d ? imm_d : '0;
    end

    hmmm_onehot_dec #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_out_dec (
        .idx    (src_d),
        .en     (active_d && src_on_bus_d),
        .onehot (out_en_d)
    );

    hmmm_onehot_dec #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_in_dec (
        .idx    (dst_d),
        .en     (load_d),
        .onehot (in_en_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            imm_en_q   <= 1'b0;
            imm_q      <= '0;
            done_q     <= 1'b0;
            out_en_q   <= '0;
            in_en_q    <= '0;
            drv_q      <= 1'b0;
            drv_data_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            imm_en_q   <= imm_en_d;
            imm_q      <= imm_d;
            done_q     <= done_d;
            out_en_q   <= out_en_d;
            in_en_q    <= in_en_d;
            drv_q      <= drv_d;
            drv_data_q <= drv_data_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign reg_out_en = out_en_q;
    assign reg_in_en  = in_en_q;
    assign data       = drv_q ? drv_data_q : {N{1'bz}};

endmodule
